// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants, baud divider.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
//
// The divider function is shared with the transmitter's baud logic, so both ends
// derive the same oversample period from the same clock/baud pair.
package uart_pkg;

  localparam int unsigned OS_RATE = 16;  // oversample ticks per bit
  localparam int unsigned SMP_LO  = 7;   // first majority sample
  localparam int unsigned SMP_MID = 8;   // centre sample
  localparam int unsigned SMP_HI  = 9;   // last sample; the bit is resolved here

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * OS_RATE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/my_uart_rx_os_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take rx_data on the rx_done strobe.
//
// master: the receiver (samples rs232_rx, drives results)
// slave : the line driver / byte consumer
interface my_uart_rx_os_if;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rs232_rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rs232_rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while en is high.
// Latency: first tick DIV cycles after en rises; count clears whenever en is low.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), en (count enable), tick (1-cycle strobe).
module uart_os_tick #(
  parameter int unsigned DIV = 27,
  parameter int          DLY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  // DLY only shifts assignment timing in behavioural models; nothing to build here.
  if (DLY < 0) begin : g_dly_negative
  end

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/my_uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with 2-of-3 majority voting and break handling.
// Latency: rx_done/frame_err at 153*DIV+3 clocks after the start-bit falling edge (mid-stop).
// Backpressure: none; rx_data must be captured within one frame time of rx_done.
//
// Ports: clk, rst_n (async active-low), bus.master:
//   rs232_rx in, rx_data[7:0] out, rx_done out (pulse), frame_err out (pulse), rx_busy out.
module my_uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int          DLY      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  my_uart_rx_os_if.master  bus
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  // Line synchronizer plus history flop; all reset to the idle (high) level
  // so coming out of reset never looks like a start edge.
  logic sync1, sync2, hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= bus.rs232_rx;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  wire fall = hist & ~sync2;

  rx_state_t  state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       s0_q, s0_d, s1_q, s1_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       tick;

  // Tick counter only runs while busy, so it is already at zero when the
  // next start edge raises busy.
  uart_os_tick #(
    .DIV (DIV),
    .DLY (DLY)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .tick  (tick)
  );

  wire [3:0] os_nxt = os_q + 4'd1;
  // The third vote is taken live from the synchronizer on the resolving tick.
  wire       maj    = (s0_q & s1_q) | (s0_q & sync2) | (s1_q & sync2);
  wire       mid_pt = tick && (os_nxt == 4'(SMP_HI));

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    if (tick) begin
      os_d = os_nxt;
      if (os_nxt == 4'(SMP_LO))  s0_d = sync2;
      if (os_nxt == 4'(SMP_MID)) s1_d = sync2;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          busy_d  = 1'b1;
          os_d    = 4'd0;
        end
      end
      ST_START: begin
        if (mid_pt) begin
          if (!maj) begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
          end else begin
            // Too short to be a start bit: drop it silently.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (mid_pt) begin
          sh_d[bit_q] = maj;
          bit_d       = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop gives half a bit of slack before the next start edge.
        if (mid_pt) begin
          busy_d = 1'b0;
          if (maj) begin
            data_d  = sh_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before another start is armed.
        if (sync2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      os_q    <= 4'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.rx_busy   = busy_q;

endmodule

// File: doc/my_uart_rx_os.md
# my_uart_rx_os

16x-oversampling UART receiver for 8N1 serial frames on `rs232_rx`. It is the receive-side counterpart of the design's UART transmitter and delivers bytes to the logic-analysis command path. It generates its own oversample tick and validates start and stop bits. Each good byte is presented with a one-cycle `rx_done` strobe; a bad stop bit raises `frame_err` instead.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in baud.
- `DLY`, default 0: simulation-only delay on non-blocking assignments.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rs232_rx`  in  1: asynchronous serial line; idles high.
- `rx_data`  out  8: last received byte; LSB is received first.
- `rx_done`  out  1: one-cycle pulse; `rx_data` is valid with it.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples low.
- `rx_busy`  out  1: high from start-edge detection until the frame ends.

## Operation
- Reset values: `rx_data`=0, `rx_done`=0, `frame_err`=0, `rx_busy`=0, state=IDLE, synchronizer flops=1.
- Input path: 2-flop synchronizer, plus one history flop for falling-edge detection.
- Tick: `DIV = CLK_FREQ/(BAUD*16)`, integer-truncated, minimum 1. The tick counter runs only while `rx_busy` is high and restarts at 0 on the start edge. `os_cnt` (4 bits) advances once per tick.
- Bit sampling: the synchronized line is sampled at `os_cnt` = 7, 8 and 9. The bit value is the 2-of-3 majority, resolved at `os_cnt`=9.
- FSM states:
  - IDLE: a falling edge on the synchronized line → START and `rx_busy`=1.
  - START: the majority at `os_cnt`=9 decides:
    - 0 → DATA with `bit_cnt`=0.
    - 1 (glitch) → IDLE; no pulse.
  - DATA: each majority is shifted in at `rx_data_sh[bit_cnt]`. After `bit_cnt`=7 → STOP.
  - STOP: the majority decides:
    - 1 → `rx_data`←shift register, `rx_done`=1 for one cycle, then IDLE.
    - 0 → `frame_err`=1 for one cycle, `rx_data` unchanged, then BREAK.
  - BREAK: wait until the synchronized line is high, then IDLE. This prevents a held-low line (break condition) from retriggering.
- `rx_busy` drops in the same cycle as `rx_done` or `frame_err`.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge one half-bit later is accepted.
- Reset mid-frame clears everything immediately; no pulse is emitted. The next frame needs a fresh falling edge.
- `rx_data` holds its value between frames.

## Timing
- Bit period is `16*DIV` clocks. With the defaults, `DIV`=27 and the bit period is 432 clocks.
- Edge detection: 2 cycles after `rs232_rx` falls (synchronizer), start state is entered on the 3rd edge.
- Result pulse: `rx_done`/`frame_err` asserts `9*16*DIV + 9*DIV + 3` clocks after the pin's falling edge (±1). That is mid-stop-bit, roughly 9.56 bit periods.
- Sampling-point tolerance: ±(7/16) bit at the sample center. The combined clock mismatch of both ends must stay below 4%.
- Each pulse is exactly 1 cycle; `rx_done` and `frame_err` are never high together.
- There is no back-pressure: the consumer must capture `rx_data` within one frame time (10 bit periods).

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - `OS_RATE`=16 and sample indices 7/8/9.
  - The `DIV` computation, as a constant function, so the transmitter's baud logic can share it.
- One sub-module, `uart_os_tick`:
  - Parameters `DIV`, `DLY`; ports `clk`, `rst_n`, `en`, `tick`.
  - Produces a one-cycle tick every `DIV` clocks while `en` is high; the count clears when `en` is low.
- The FSM, majority voter and shift register stay in `my_uart_rx_os`.

## Test plan
- Single byte: send 0xA5 at 115200 baud (50 MHz clock) → one `rx_done` pulse with `rx_data`=0xA5, `frame_err`=0, and pulse time within ±1 clock of the formula.
- Start glitch: pull the line low for 100 clocks, then high → no pulse; `rx_busy` returns to 0 within 9*27+3 clocks. A following 0x3C is received correctly.
- Framing error: send 0x55 with the stop bit 0, then hold low for 2 bit periods, then high → one `frame_err` pulse and `rx_data` unchanged. No frame starts until the line goes high; the next byte 0x81 is received OK.
- Back-to-back: send 0x00, 0xFF, 0x7E with zero idle between frames → three `rx_done` pulses in order with correct data.
- Noise: inject a 1-clock inverted spike at `os_cnt`=8 of every data bit of 0x96 → `rx_data`=0x96 (majority rejects the spikes).
- Reset mid-frame: assert `rst_n` low during bit 4 of 0x5A → all outputs read 0 immediately; no pulse. After release, a fresh 0x5A is received OK.
